fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised fetch front-end that generates the PC sequence and issues instruction reads over a request/response memory port.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/jump), which flushes buffered and in-flight instructions.
- Sits between the instruction memory and decode in the next-generation processor top.

Parameters:
- AWIDTH, 32, address/PC width in bits.
- DWIDTH, 32, instruction width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PC_RESET, 32'h0100_0000, first fetch address after reset; truncated to AWIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset; 0 = reset.
- mem_req_o  out  1  read request valid.
- mem_addr_o  out  AWIDTH  read address, word-aligned.
- mem_ready_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DWIDTH  read data.
- redirect_i  in  1  redirect strobe.
- redirect_pc_i  in  AWIDTH  redirect target; bits [1:0] ignored and forced to 0.
- insn_valid_o  out  1  FIFO head valid.
- insn_ready_i  in  1  decode accepts head.
- insn_o  out  DWIDTH  head instruction.
- pc_o  out  AWIDTH  head PC.
- perf_fetched_o  out  32  see Optional Feature.
- perf_dropped_o  out  32  see Optional Feature.
- perf_stall_o  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0 at edge): next_pc=PC_RESET; FIFO empty; state=ISSUE. mem_req_o=0, insn_valid_o=0, insn_o=0, pc_o=0 and perf counters=0 while reset is held. Reset mid-transaction abandons any outstanding response, which is not accepted into the FIFO.
- At most one outstanding request.
- FSM states:
  - ISSUE: mem_req_o=1 iff count < DEPTH and no redirect_i this cycle; mem_addr_o=next_pc. On mem_req_o & mem_ready_i: go to WAIT, next_pc += 4 (wraps mod 2^AWIDTH), latch the issued PC as pend_pc.
  - WAIT: on mem_rvalid_i, push {mem_rdata_i, pend_pc} and go to ISSUE. Credit rule guarantees the FIFO has room.
  - DROP: stale response outstanding; on mem_rvalid_i, discard the data and go to ISSUE.
- Redirect (redirect_i=1):
  - FIFO flushed in the same edge; insn_valid_o=0 the next cycle.
  - next_pc = {redirect_pc_i[AWIDTH-1:2], 2'b00}.
  - WAIT goes to DROP. DROP stays in DROP. ISSUE stays in ISSUE (mem_req_o is suppressed that cycle).
  - A response arriving in the same cycle as redirect_i is discarded.
  - A pop in the same cycle as redirect_i has no effect beyond the flush.
- FIFO:
  - Head valid when count > 0.
  - Pop on insn_valid_o & insn_ready_i.
  - Simultaneous push and pop leaves count unchanged, including when full or empty. On empty, the pushed entry becomes visible the next cycle; there is no bypass.
  - Head outputs are registered; insn_o and pc_o hold their last value when empty.
- Latency: from request acceptance with 1-cycle memory, the instruction is visible on insn_valid_o 2 cycles after acceptance. Peak throughput is one instruction per 2 cycles (single outstanding).
- mem_rvalid_i in ISSUE is a protocol error: ignored. An assertion flags it in simulation.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: three 32-bit saturating counters, cleared by reset.
  - perf_fetched_o: FIFO pushes.
  - perf_dropped_o: responses discarded in DROP or on a redirect cycle, plus entries flushed by redirect (count added).
  - perf_stall_o: cycles with insn_ready_i=1 and insn_valid_o=0.
- Undefined: the ports exist but are tied to 0, and no counter flops are inferred.

Decomposition:
- Package fetch_pkg holds:
  - fq_state_e enum {FQ_ISSUE, FQ_WAIT, FQ_DROP};
  - fq_entry_t struct {insn, pc};
  - INSN_BYTES=4 constant.
- One sub-module: fq_fifo (DEPTH x fq_entry_t, push/pop/flush, count, registered head).

Test Plan:
- Reset release, 1-cycle memory, insn_ready_i=1 -> mem_addr_o sequence 0x0100_0000, 0x0100_0004, 0x0100_0008; pc_o matches; first insn_valid_o 2 cycles after first acceptance.
- insn_ready_i=0, DEPTH=4 -> exactly 4 pushes, then mem_req_o=0 held. Release ready -> one pop per cycle and fetch resumes at 0x0100_0010.
- Redirect to 0x0200_0007 while in WAIT -> in-flight response discarded, FIFO empty, next accepted mem_addr_o=0x0200_0004. Check pc_o reads 0x0200_0004 on the next delivered instruction.
- redirect_i coincident with mem_rvalid_i and a pop -> data not delivered, count=0, perf_dropped_o increments (macro on).
- next_pc=0xFFFF_FFFC fetch -> following address 0x0000_0000.
- rst=0 asserted during WAIT, memory responds the next cycle -> response ignored; after release, fetch restarts at PC_RESET with empty FIFO.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue block.
package fetch_pkg;

  // Fetch sequencer states: free to issue, waiting on a live response,
  // or waiting on a response that a redirect has made stale.
  typedef enum logic [1:0] {
    FQ_ISSUE = 2'd0,
    FQ_WAIT  = 2'd1,
    FQ_DROP  = 2'd2
  } fq_state_e;

  // Default buffered entry layout (32-bit instruction and PC).
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fq_entry_t;

  // Bytes per instruction word; also the PC increment.
  localparam int INSN_BYTES = 4;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] fq_sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: DEPTH-entry FIFO with flush and a registered head entry.
// The head register is reloaded every cycle from the entry that will be at
// the front after this edge, so the head is visible one cycle after a push
// into an empty FIFO and holds its last value while empty.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output entry_t                 head_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  entry_t        head_q, head_d;
  logic          do_push, do_pop;

  // Next pointers, occupancy and the entry that becomes the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_push = push_i;
      do_pop  = pop_i && (count_q != '0);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (count_d != '0) begin
        // The new head may be the entry being written this very edge.
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
      end
    end
  end

  // Storage array, written only; never reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC sequencer plus single-outstanding instruction fetch into a
// small FIFO feeding decode. Redirects flush the FIFO and mark any in-flight
// response stale. Optional performance counters are built when the macro
// FETCH_QUEUE_PERF_EN is defined; otherwise the perf ports read zero.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          AWIDTH   = 32,
  parameter int          DWIDTH   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_dropped_o,
  output logic [31:0]       perf_stall_o
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~AWIDTH'(3);
  localparam logic [AWIDTH-1:0] PC_RESET_C = AWIDTH'(PC_RESET) & ALIGN_MASK;

  typedef struct packed {
    logic [DWIDTH-1:0] insn;
    logic [AWIDTH-1:0] pc;
  } fq_slot_t;

  fq_state_e         state_q, state_d;
  logic [AWIDTH-1:0] next_pc_q, next_pc_d;
  logic [AWIDTH-1:0] pend_pc_q, pend_pc_d;
  logic              push, pop;
  fq_slot_t          push_data, head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_valid;

  // Sequencer next state, PC update and request generation.
  always_comb begin
    state_d   = state_q;
    next_pc_d = next_pc_q;
    pend_pc_d = pend_pc_q;
    push      = 1'b0;
    // The credit check at issue time guarantees room for the response,
    // since nothing else can push while the single request is in flight.
    mem_req_o = rst && (state_q == FQ_ISSUE) && (fifo_count < DEPTH_C) && !redirect_i;
    unique case (state_q)
      FQ_ISSUE: begin
        if (mem_req_o && mem_ready_i) begin
          state_d   = FQ_WAIT;
          pend_pc_d = next_pc_q;
          next_pc_d = next_pc_q + AWIDTH'(INSN_BYTES);
        end
      end
      FQ_WAIT: begin
        // A response landing with a redirect is consumed and thrown away;
        // nothing is left outstanding, so issuing can resume directly.
        if (mem_rvalid_i) begin
          push    = !redirect_i;
          state_d = FQ_ISSUE;
        end else if (redirect_i) begin
          state_d = FQ_DROP;
        end
      end
      FQ_DROP: begin
        if (mem_rvalid_i) state_d = FQ_ISSUE;
      end
      default: state_d = FQ_ISSUE;
    endcase
    if (redirect_i) next_pc_d = redirect_pc_i & ALIGN_MASK;
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FQ_ISSUE;
      next_pc_q <= PC_RESET_C;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      next_pc_q <= next_pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign mem_addr_o = next_pc_q;
  assign push_data  = '{insn: mem_rdata_i, pc: pend_pc_q};
  assign pop        = fifo_valid && insn_ready_i && !redirect_i;

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fq_slot_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .head_o      (head)
  );

  assign insn_valid_o = fifo_valid;
  assign insn_o       = head.insn;
  assign pc_o         = head.pc;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q, perf_stall_q;
  logic        resp_drop;
  logic [31:0] drop_inc;

  assign resp_drop = mem_rvalid_i &&
                     ((state_q == FQ_DROP) || ((state_q == FQ_WAIT) && redirect_i));
  assign drop_inc  = 32'(resp_drop) + (redirect_i ? 32'(fifo_count) : 32'd0);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= fq_sat_add(perf_fetched_q, 32'(push));
      perf_dropped_q <= fq_sat_add(perf_dropped_q, drop_inc);
      perf_stall_q   <= fq_sat_add(perf_stall_q, 32'(insn_ready_i && !fifo_valid));
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_dropped_o = perf_dropped_q;
  assign perf_stall_o   = perf_stall_q;
`else
  assign perf_fetched_o = 32'd0;
  assign perf_dropped_o = 32'd0;
  assign perf_stall_o   = 32'd0;
`endif

`ifndef SYNTHESIS
  // Memory must never return data while nothing is outstanding.
  a_no_rvalid_in_issue: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == FQ_ISSUE) && mem_rvalid_i));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue with a queue-based reference model
// and a simple variable-latency memory.
module tb_fetch_queue;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic          insn_valid_o;
  logic          insn_ready_i;
  logic [DW-1:0] insn_o;
  logic [AW-1:0] pc_o;
  logic [31:0]   perf_fetched_o, perf_dropped_o, perf_stall_o;

  always #5 clk = ~clk;

  fetch_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .insn_valid_o   (insn_valid_o),
    .insn_ready_i   (insn_ready_i),
    .insn_o         (insn_o),
    .pc_o           (pc_o),
    .perf_fetched_o (perf_fetched_o),
    .perf_dropped_o (perf_dropped_o),
    .perf_stall_o   (perf_stall_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_insn[$];
  logic [31:0] m_next_pc, m_pend_pc, hold_pc, hold_insn;
  bit          m_out, m_stale;
  logic [31:0] p_fetch, p_drop, p_stall;

  // Memory model state and knobs
  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int          k_ready_pct = 100;
  int          k_lat_min = 1;
  int          k_lat_max = 1;

  // Per-cycle observations and expectations
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_insn, o_pc, o_fetch, o_drop, o_stall;
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_insn, e_pc, e_fetch, e_drop, e_stall;
  bit          acc, resp_now;
  logic [31:0] acc_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_insn.delete();
    m_next_pc = PC_RST;
    m_pend_pc = '0;
    hold_pc   = '0;
    hold_insn = '0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    p_fetch   = '0;
    p_drop    = '0;
    p_stall   = '0;
  endtask

  // One clock: drive memory, sample at negedge, advance memory and model at posedge.
  task automatic step();
    mem_ready_i  = ($urandom_range(99) < k_ready_pct);
    resp_now     = mem_pend && (mem_wait == 0);
    mem_rvalid_i = resp_now;
    mem_rdata_i  = resp_now ? mem_fn(mem_addr) : $urandom();
    @(negedge clk);
    o_req   = mem_req_o;
    o_addr  = mem_addr_o;
    o_valid = insn_valid_o;
    o_insn  = insn_o;
    o_pc    = pc_o;
    o_fetch = perf_fetched_o;
    o_drop  = perf_dropped_o;
    o_stall = perf_stall_o;
    e_valid = (q_pc.size() != 0);
    if (e_valid) begin
      hold_pc   = q_pc[0];
      hold_insn = q_insn[0];
    end
    e_pc   = hold_pc;
    e_insn = hold_insn;
    e_req  = rst && !m_out && (q_pc.size() < DEPTH) && !redirect_i;
    e_addr = m_next_pc;
`ifdef FETCH_QUEUE_PERF_EN
    e_fetch = p_fetch;
    e_drop  = p_drop;
    e_stall = p_stall;
`else
    e_fetch = '0;
    e_drop  = '0;
    e_stall = '0;
`endif
    @(posedge clk);
    acc      = o_req && mem_ready_i;
    acc_addr = o_addr;
    if (resp_now) mem_pend = 1'b0;
    else if (mem_pend) mem_wait--;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = o_addr;
      mem_wait = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
    end
    if (!rst) begin
      model_reset();
    end else begin
      if (insn_ready_i && !e_valid) p_stall++;
      if (redirect_i) begin
        if (m_out && resp_now) begin
          p_drop++;
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else if (m_out) begin
          m_stale = 1'b1;
        end
        p_drop += q_pc.size();
        q_pc.delete();
        q_insn.delete();
        m_next_pc = redirect_pc_i & ~32'd3;
      end else begin
        if (e_valid && insn_ready_i) begin
          void'(q_pc.pop_front());
          void'(q_insn.pop_front());
        end
        if (m_out && resp_now) begin
          if (m_stale) p_drop++;
          else begin
            q_pc.push_back(m_pend_pc);
            q_insn.push_back(mem_fn(m_pend_pc));
            p_fetch++;
          end
          m_out   = 1'b0;
          m_stale = 1'b0;
        end
        if (acc) begin
          m_out     = 1'b1;
          m_pend_pc = m_next_pc;
          m_next_pc = m_next_pc + 32'd4;
        end
      end
    end
    #1;
  endtask

  // Hold reset long enough for any pending memory response to drain.
  task automatic do_reset();
    rst = 1'b0;
    redirect_i = 1'b0;
    step();
    step();
    for (int i = 0; i < 8 && mem_pend; i++) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    insn_ready_i = 1'b1;
    redirect_i = 1'b0;
    step(); step(); step();
    n_cmp++; if (o_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", o_req); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_insn !== 32'h0) begin n_bad++; $display("FAIL reset_insn: got %h expected 0", o_insn); end
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    n_cmp++; if (o_stall !== 32'h0) begin n_bad++; $display("FAIL reset_stall: got %0d expected 0", o_stall); end
    n_cmp++; if (o_fetch !== 32'h0 || o_drop !== 32'h0) begin
      n_bad++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", o_fetch, o_drop);
    end
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] accs[$];
    logic [31:0] seen_pc[$];
    logic [31:0] seen_insn[$];
    int acc0 = -1;
    int first_valid = -1;
    k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;
    insn_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_valid && first_valid < 0) first_valid = i;
      if (o_valid) begin seen_pc.push_back(o_pc); seen_insn.push_back(o_insn); end
      if (acc) begin
        if (acc0 < 0) acc0 = i;
        accs.push_back(acc_addr);
      end
    end
    n_cmp++;
    if (accs.size() < 3 || seen_pc.size() < 3) begin
      n_bad++; $display("FAIL seq_count: got %0d accepts/%0d pops expected >=3", accs.size(), seen_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (accs[k] !== PC_RST + 32'(4*k)) begin
          n_bad++; $display("FAIL seq_addr%0d: got %h expected %h", k, accs[k], PC_RST + 32'(4*k));
        end
        n_cmp++; if (seen_pc[k] !== PC_RST + 32'(4*k) || seen_insn[k] !== mem_fn(PC_RST + 32'(4*k))) begin
          n_bad++; $display("FAIL seq_head%0d: got %h/%h expected %h/%h", k, seen_pc[k], seen_insn[k],
                            PC_RST + 32'(4*k), mem_fn(PC_RST + 32'(4*k)));
        end
      end
    end
    n_cmp++; if (first_valid !== acc0 + 2) begin
      n_bad++; $display("FAIL seq_latency: got cycle %0d expected %0d", first_valid, acc0 + 2);
    end
    $display("test_sequential done");
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_pop = 0;
    bit got_resume = 1'b0;
    logic [31:0] resume_addr = '0;
    logic [31:0] pops[$];
    do_reset();
    k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;
    insn_ready_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (acc) n_acc++;
    end
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL bp_pushes: got %0d expected 4", n_acc); end
    n_cmp++; if (o_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_held: got %b expected 0", o_req); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", o_valid); end
    insn_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i < 4 && o_valid) begin pops.push_back(o_pc); n_pop++; end
      if (acc && !got_resume) begin got_resume = 1'b1; resume_addr = acc_addr; end
    end
    n_cmp++; if (n_pop !== 4) begin n_bad++; $display("FAIL bp_pop_rate: got %0d expected 4", n_pop); end
    for (int k = 0; k < n_pop; k++) begin
      n_cmp++; if (pops[k] !== PC_RST + 32'(4*k)) begin
        n_bad++; $display("FAIL bp_pop_pc%0d: got %h expected %h", k, pops[k], PC_RST + 32'(4*k));
      end
    end
    n_cmp++; if (!got_resume || resume_addr !== 32'h0100_0010) begin
      n_bad++; $display("FAIL bp_resume: got %h (seen %0d) expected 01000010", resume_addr, got_resume);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_wait();
    bit got_acc = 1'b0;
    bit got_del = 1'b0;
    logic [31:0] nacc = '0;
    logic [31:0] del_pc = '0;
    logic [31:0] del_insn = '0;
    do_reset();
    k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;
    insn_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    k_lat_min = 3; k_lat_max = 3;
    for (int i = 0; i < 6 && !acc; i++) step();
    n_cmp++; if (!acc) begin n_bad++; $display("FAIL rw_accept_timeout: got none expected accept"); end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0200_0007;
    step();
    redirect_i = 1'b0;
    insn_ready_i = 1'b1;
    k_lat_min = 1; k_lat_max = 1;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rw_flush: got valid %b expected 0", o_valid); end
    for (int i = 0; i < 20 && !got_del; i++) begin
      step();
      if (acc && !got_acc) begin got_acc = 1'b1; nacc = acc_addr; end
      if (o_valid) begin got_del = 1'b1; del_pc = o_pc; del_insn = o_insn; end
    end
    n_cmp++; if (!got_acc || nacc !== 32'h0200_0004) begin
      n_bad++; $display("FAIL rw_next_addr: got %h expected 02000004", nacc);
    end
    n_cmp++; if (!got_del || del_pc !== 32'h0200_0004 || del_insn !== mem_fn(32'h0200_0004)) begin
      n_bad++; $display("FAIL rw_delivered: got %h/%h expected 02000004/%h", del_pc, del_insn, mem_fn(32'h0200_0004));
    end
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] d0;
    int s0;
    bit got_del = 1'b0;
    logic [31:0] del_pc = '0;
    do_reset();
    k_ready_pct = 100; k_lat_min = 2; k_lat_max = 2;
    insn_ready_i = 1'b0;
    for (int i = 0; i < 30 && !(q_pc.size() >= 2 && mem_pend && mem_wait == 0); i++) step();
    n_cmp++; if (!(q_pc.size() >= 2 && mem_pend && mem_wait == 0)) begin
      n_bad++; $display("FAIL rc_setup_timeout: got size %0d expected >=2 with response due", q_pc.size());
    end
    d0 = p_drop;
    s0 = q_pc.size();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0300_0000;
    insn_ready_i = 1'b1;
    step();
    redirect_i = 1'b0;
    k_lat_min = 1; k_lat_max = 1;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rc_flush: got valid %b expected 0", o_valid); end
`ifdef FETCH_QUEUE_PERF_EN
    n_cmp++; if (o_drop !== d0 + 32'd1 + 32'(s0)) begin
      n_bad++; $display("FAIL rc_dropped: got %0d expected %0d", o_drop, d0 + 32'd1 + 32'(s0));
    end
`else
    n_cmp++; if (o_drop !== 32'd0) begin n_bad++; $display("FAIL rc_dropped_tied: got %0d expected 0", o_drop); end
`endif
    for (int i = 0; i < 20 && !got_del; i++) begin
      step();
      if (o_valid) begin got_del = 1'b1; del_pc = o_pc; end
    end
    n_cmp++; if (!got_del || del_pc !== 32'h0300_0000) begin
      n_bad++; $display("FAIL rc_delivered: got %h expected 03000000", del_pc);
    end
    $display("test_redirect_coincident done");
  endtask

  task automatic test_wrap();
    logic [31:0] accs[$];
    do_reset();
    k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;
    insn_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 10 && accs.size() < 2; i++) begin
      step();
      if (acc) accs.push_back(acc_addr);
    end
    n_cmp++;
    if (accs.size() < 2) begin
      n_bad++; $display("FAIL wrap_timeout: got %0d accepts expected 2", accs.size());
    end else if (accs[0] !== 32'hFFFF_FFFC || accs[1] !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap_addr: got %h,%h expected fffffffc,00000000", accs[0], accs[1]);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    bit saw_resp = 1'b0;
    bit got_acc = 1'b0;
    bit got_del = 1'b0;
    logic [31:0] nacc = '0;
    logic [31:0] del_pc = '0;
    do_reset();
    k_ready_pct = 100; k_lat_min = 2; k_lat_max = 2;
    insn_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc && i > 8) break;
    end
    rst = 1'b0;
    step();
    step();
    saw_resp = resp_now;
    rst = 1'b1;
    k_lat_min = 1; k_lat_max = 1;
    step();
    n_cmp++; if (!saw_resp) begin n_bad++; $display("FAIL rm_setup: got no response expected one during reset"); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rm_empty: got valid %b expected 0", o_valid); end
    if (acc) begin got_acc = 1'b1; nacc = acc_addr; end
    for (int i = 0; i < 12 && !got_del; i++) begin
      step();
      if (acc && !got_acc) begin got_acc = 1'b1; nacc = acc_addr; end
      if (o_valid) begin got_del = 1'b1; del_pc = o_pc; end
    end
    n_cmp++; if (!got_acc || nacc !== PC_RST) begin
      n_bad++; $display("FAIL rm_restart_addr: got %h expected %h", nacc, PC_RST);
    end
    n_cmp++; if (!got_del || del_pc !== PC_RST) begin
      n_bad++; $display("FAIL rm_first_pc: got %h expected %h", del_pc, PC_RST);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int bad0 = n_bad;
    do_reset();
    k_ready_pct = 70; k_lat_min = 1; k_lat_max = 3;
    for (int i = 0; i < 1500 && (n_bad - bad0) < 20; i++) begin
      insn_ready_i = ($urandom_range(9) < 6);
      redirect_i = ($urandom_range(24) == 0);
      redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      step();
      n_cmp++; if (o_req !== e_req) begin n_bad++; $display("FAIL rnd_req @%0d: got %b expected %b", i, o_req, e_req); end
      n_cmp++; if (e_req && o_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr @%0d: got %h expected %h", i, o_addr, e_addr); end
      n_cmp++; if (o_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid @%0d: got %b expected %b", i, o_valid, e_valid); end
      n_cmp++; if (o_pc !== e_pc || o_insn !== e_insn) begin
        n_bad++; $display("FAIL rnd_head @%0d: got %h/%h expected %h/%h", i, o_pc, o_insn, e_pc, e_insn);
      end
      n_cmp++; if (o_fetch !== e_fetch || o_drop !== e_drop || o_stall !== e_stall) begin
        n_bad++; $display("FAIL rnd_perf @%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                          o_fetch, o_drop, o_stall, e_fetch, e_drop, e_stall);
      end
    end
    redirect_i = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0;
    mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    insn_ready_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
